data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width; depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning access wait states between request accept and response.
REQ-003 SHALL have port clk  input  1  the single clock; all logic updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  the responder accepts a request this cycle.
REQ-007 SHALL have port req_wea  input  4  byte write enables; bit i covers data bits [8i+7:8i]; 4'b0000 means a read.
REQ-008 SHALL have port req_addr  input  32  word address; index is req_addr[ADDR_W-1:0].
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port resp_valid  output  1  a response is presented.
REQ-011 SHALL have port resp_ready  input  1  the initiator accepts the response.
REQ-012 SHALL have port resp_rdata  output  32  read data, or the post-write word.
REQ-013 SHALL have port resp_err  output  1  the address was out of range.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted on a cycle with req_valid=1 and req_ready=1.
REQ-016 SHALL capture req_wea, req_addr and req_wdata into internal registers on accept; later input changes are ignored until the next accept.
REQ-017 On accept, SHALL go to WAIT with the wait counter loaded to WAIT_CYCLES-1 if WAIT_CYCLES>0, or directly to RESP if WAIT_CYCLES=0.
REQ-018 In WAIT, SHALL decrement the counter each cycle and leave WAIT on the cycle the counter equals 0.
REQ-019 SHALL make the commit on the WAIT->RESP transition, or on the IDLE->RESP transition when WAIT_CYCLES=0.
- Write: update only the enabled bytes of the addressed word.
- Read: register the word into resp_rdata.
REQ-020 For writes, SHALL load resp_rdata with the merged post-write word, i.e. read-after-write data within the same transaction.
REQ-021 SHALL flag out of range if any of req_addr[31:ADDR_W] is nonzero.
- Commit: no memory write; resp_rdata=0; resp_err=1.
- Otherwise resp_err=0.
REQ-022 SHALL hold resp_valid=1 in RESP with resp_rdata and resp_err stable until resp_ready=1, then return to IDLE on the next edge.
REQ-023 SHALL NOT accept a new request in the same cycle that a response handshake completes; the minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
REQ-024 SHALL give accept-to-resp_valid latency of WAIT_CYCLES+1 cycles.
REQ-025 SHALL store memory in a register array with no reset of its contents; contents persist across rst.
REQ-026 SHALL allow req_wea=4'b1111 with full-word writes; partial enables leave the other bytes unchanged.

Reset
REQ-027 While rst=1 at a rising edge, SHALL set state=IDLE, counter=0, resp_valid=0, resp_rdata=0 and resp_err=0; req_ready reads 0 during the rst cycle.
REQ-028 rst in WAIT SHALL abort the transaction: no write commit and no response.
- rst in RESP SHALL drop resp_valid; a write that already committed remains in memory.
REQ-029 SHALL accept the first request on the first edge after rst deasserts, if req_valid=1.

Verification
REQ-030 Basic write/read, WAIT_CYCLES=1:
- write addr 0 data 0x00000001 wea 4'b1111 -> resp_rdata=0x00000001 two cycles after accept;
- write addr 1 data 0x00000002;
- read addr 1 -> 0x00000002;
- read addr 0 -> 0x00000001.
REQ-031 Byte enables:
- write addr 2 data 0xAABBCCDD wea 4'b1111;
- then write 0x11223344 wea 4'b0101 -> resp_rdata=0xAA22CC44;
- read addr 2 -> 0xAA22CC44.
REQ-032 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid stays 1, data stable, req_ready=0 throughout; handshake -> IDLE next cycle.
REQ-033 Out of range: write addr 0x00000400 (ADDR_W=10) data 0xFFFFFFFF -> resp_err=1, resp_rdata=0; read addr 0 is unchanged.
REQ-034 Reset in WAIT:
- with WAIT_CYCLES=3, write addr 5 data 0x5A5A5A5A and assert rst on the 2nd WAIT cycle -> no response;
- after reset, read addr 5 -> prior contents, not 0x5A5A5A5A.
REQ-035 WAIT_CYCLES=0: back-to-back requests with resp_ready tied 1 -> resp_valid one cycle after each accept; accepts no closer than every 2 cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-port word memory behind a valid/ready request channel and a valid/ready
// response channel, with a fixed number of wait states per access.
module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_wea,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic       NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_cnt;
  logic [3:0]         r_wea;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [31:0]        r_mem [0:DEPTH-1];

  logic               w_accept;
  logic               w_commit;
  logic               w_err;
  logic [3:0]         w_c_wea;
  logic [31:0]        w_c_addr;
  logic [31:0]        w_c_wdata;
  logic [ADDR_W-1:0]  w_idx;
  logic [31:0]        w_old_word;
  logic [31:0]        w_merged;

  assign req_ready  = (r_state == IDLE) && !rst;
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // With no wait states the commit happens on the accept edge, so the
  // operands come straight from the request port instead of the capture regs.
  assign w_c_wea   = NO_WAIT ? req_wea   : r_wea;
  assign w_c_addr  = NO_WAIT ? req_addr  : r_addr;
  assign w_c_wdata = NO_WAIT ? req_wdata : r_wdata;

  assign w_commit = !rst && (((r_state == WAIT) && (r_cnt == 4'd0)) ||
                             (NO_WAIT && w_accept));

  assign w_err      = |w_c_addr[31:ADDR_W];
  assign w_idx      = w_c_addr[ADDR_W-1:0];
  assign w_old_word = r_mem[w_idx];

  // A read (no enables) falls out of the merge as the unchanged stored word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_merge
      assign w_merged[8*gi +: 8] = w_c_wea[gi] ? w_c_wdata[8*gi +: 8]
                                               : w_old_word[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = NO_WAIT ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_wea   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_INIT;
        r_wea   <= req_wea;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rdata <= w_err ? 32'd0 : w_merged;
        r_err   <= w_err;
      end
    end
  end

  // Contents are deliberately not reset so they survive rst.
  always_ff @(posedge clk) begin
    if (w_commit && !w_err && (|w_c_wea)) begin
      r_mem[w_idx] <= w_merged;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (1, 3 and 0 wait states) driven
// from a shared vector table, a response scoreboard and hand-written corner cases.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a  [3];
  logic        req_ready_a  [3];
  logic [3:0]  req_wea_a    [3];
  logic [31:0] req_addr_a   [3];
  logic [31:0] req_wdata_a  [3];
  logic        resp_valid_a [3];
  logic        resp_ready_a [3];
  logic [31:0] resp_rdata_a [3];
  logic        resp_err_a   [3];

  int wc [3] = '{1, 3, 0};
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  wea;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t sb_q [$];
  exp_t mon_e;
  vec_t vecs [14];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_wea(req_wea_a[0]),
    .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]),
    .resp_valid(resp_valid_a[0]), .resp_ready(resp_ready_a[0]),
    .resp_rdata(resp_rdata_a[0]), .resp_err(resp_err_a[0])
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_wea(req_wea_a[1]),
    .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]),
    .resp_valid(resp_valid_a[1]), .resp_ready(resp_ready_a[1]),
    .resp_rdata(resp_rdata_a[1]), .resp_err(resp_err_a[1])
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]), .req_wea(req_wea_a[2]),
    .req_addr(req_addr_a[2]), .req_wdata(req_wdata_a[2]),
    .resp_valid(resp_valid_a[2]), .resp_ready(resp_ready_a[2]),
    .resp_rdata(resp_rdata_a[2]), .resp_err(resp_err_a[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed response handshake pops one expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (resp_valid_a[k] && resp_ready_a[k]) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: inst %0d responded with %h, expected no response",
                   k, resp_rdata_a[k]);
        end else begin
          mon_e = sb_q.pop_front();
          chk($sformatf("sb_inst(k=%0d)", k), k, mon_e.k);
          chk($sformatf("sb_rdata(k=%0d)", k), resp_rdata_a[k], mon_e.rdata);
          chk($sformatf("sb_err(k=%0d)", k), resp_err_a[k], mon_e.err);
          $display("resp inst=%0d rdata=%h err=%0b", k, resp_rdata_a[k], resp_err_a[k]);
        end
      end
    end
  end

  task automatic do_req(input int k, input logic [3:0] wea, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input int hold);
    int lat;
    int guard;
    step();
    resp_ready_a[k] = (hold == 0);
    req_valid_a[k]  = 1'b1;
    req_wea_a[k]    = wea;
    req_addr_a[k]   = addr;
    req_wdata_a[k]  = wdata;
    guard = 0;
    while (!req_ready_a[k] && guard < 20) begin
      step();
      guard++;
    end
    if (!req_ready_a[k]) begin
      n_checks++;
      $display("FAIL accept_timeout: inst %0d req_ready stayed %b, expected 1", k, req_ready_a[k]);
      req_valid_a[k] = 1'b0;
      return;
    end
    sb_q.push_back(exp_t'{k, exp_rd, exp_err});
    $display("req  inst=%0d wea=%b addr=%h wdata=%h exp=%h err=%0b", k, wea, addr, wdata,
             exp_rd, exp_err);
    step();
    // Scramble the request port to show the captured copy is what gets used.
    req_valid_a[k] = 1'b0;
    req_wea_a[k]   = ~wea;
    req_addr_a[k]  = addr ^ 32'h1;
    req_wdata_a[k] = ~wdata;
    lat = 1;
    while (!resp_valid_a[k] && lat < 40) begin
      step();
      lat++;
    end
    chk($sformatf("latency(k=%0d)", k), lat, wc[k] + 1);
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", resp_valid_a[k], 1);
      chk("bp_rdata", resp_rdata_a[k], exp_rd);
      chk("bp_err", resp_err_a[k], exp_err);
      chk("bp_req_ready", req_ready_a[k], 0);
      step();
    end
    resp_ready_a[k] = 1'b1;
    chk("hs_req_ready", req_ready_a[k], 0);
    step();
    chk("post_hs_valid", resp_valid_a[k], 0);
    chk("post_hs_req_ready", req_ready_a[k], 1);
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[1]  = '{4'b1111, 32'h0000_0001, 32'h0000_0002, 32'h0000_0002, 1'b0};
    vecs[2]  = '{4'b0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0002, 1'b0};
    vecs[3]  = '{4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[4]  = '{4'b1111, 32'h0000_0002, 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b0};
    vecs[5]  = '{4'b0101, 32'h0000_0002, 32'h1122_3344, 32'hAA22_CC44, 1'b0};
    vecs[6]  = '{4'b0000, 32'h0000_0002, 32'h0000_0000, 32'hAA22_CC44, 1'b0};
    vecs[7]  = '{4'b1111, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[8]  = '{4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[9]  = '{4'b1111, 32'h0000_03FF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{4'b1000, 32'h0000_03FF, 32'h5500_0000, 32'h55AD_BEEF, 1'b0};
    vecs[11] = '{4'b0010, 32'h0000_03FF, 32'h0000_AA00, 32'h55AD_AAEF, 1'b0};
    vecs[12] = '{4'b0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[13] = '{4'b0000, 32'h0000_03FF, 32'h0000_0000, 32'h55AD_AAEF, 1'b0};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid_a[k]  = 1'b0;
      req_wea_a[k]    = 4'd0;
      req_addr_a[k]   = 32'd0;
      req_wdata_a[k]  = 32'd0;
      resp_ready_a[k] = 1'b1;
    end
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", req_ready_a[k], 0);
      chk("rst_resp_valid", resp_valid_a[k], 0);
      chk("rst_resp_rdata", resp_rdata_a[k], 32'd0);
      chk("rst_resp_err", resp_err_a[k], 0);
    end
    rst = 1'b0;
    #1;
    chk("idle_req_ready", req_ready_a[0], 1);

    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < 14; v++) begin
        do_req(k, vecs[v].wea, vecs[v].addr, vecs[v].wdata, vecs[v].rdata, vecs[v].err, 0);
      end
    end

    // Backpressure: response held for 5 cycles.
    do_req(0, 4'b1111, 32'h0000_0003, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 5);
    do_req(0, 4'b0000, 32'h0000_0003, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 0);

    // Reset during the second WAIT cycle aborts the write.
    do_req(1, 4'b1111, 32'h0000_0005, 32'h1234_5678, 32'h1234_5678, 1'b0, 0);
    step();
    req_valid_a[1] = 1'b1;
    req_wea_a[1]   = 4'b1111;
    req_addr_a[1]  = 32'h0000_0005;
    req_wdata_a[1] = 32'h5A5A_5A5A;
    chk("abort_req_ready", req_ready_a[1], 1);
    $display("req  inst=1 wea=1111 addr=00000005 wdata=5a5a5a5a (reset in WAIT)");
    step();
    req_valid_a[1] = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("abort_rst_req_ready", req_ready_a[1], 0);
    chk("abort_rst_resp_valid", resp_valid_a[1], 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_resp", resp_valid_a[1], 0);
    end
    do_req(1, 4'b0000, 32'h0000_0005, 32'h0000_0000, 32'h1234_5678, 1'b0, 0);

    // Reset while a committed write sits in RESP: response drops, data stays.
    step();
    resp_ready_a[0] = 1'b0;
    req_valid_a[0]  = 1'b1;
    req_wea_a[0]    = 4'b1111;
    req_addr_a[0]   = 32'h0000_0006;
    req_wdata_a[0]  = 32'h0000_0066;
    $display("req  inst=0 wea=1111 addr=00000006 wdata=00000066 (reset in RESP)");
    step();
    req_valid_a[0] = 1'b0;
    step();
    chk("resp_rst_valid_before", resp_valid_a[0], 1);
    rst = 1'b1;
    step();
    chk("resp_rst_valid_after", resp_valid_a[0], 0);
    chk("resp_rst_rdata_after", resp_rdata_a[0], 32'd0);
    rst = 1'b0;
    do_req(0, 4'b0000, 32'h0000_0006, 32'h0000_0000, 32'h0000_0066, 1'b0, 0);

    // Zero wait states, request held valid continuously.
    begin : b2b
      int   last_acc;
      int   nacc;
      logic acc;
      logic prev_acc;
      step();
      resp_ready_a[2] = 1'b1;
      req_valid_a[2]  = 1'b1;
      req_wea_a[2]    = 4'b1111;
      req_addr_a[2]   = 32'h0000_0010;
      req_wdata_a[2]  = 32'hC0DE_0000;
      last_acc = -1;
      nacc     = 0;
      prev_acc = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
        if (prev_acc) chk("b2b_resp_valid", resp_valid_a[2], 1);
        acc = req_valid_a[2] && req_ready_a[2];
        if (acc) begin
          sb_q.push_back(exp_t'{2, req_wdata_a[2], 1'b0});
          $display("req  inst=2 wea=1111 addr=%h wdata=%h (back-to-back)",
                   req_addr_a[2], req_wdata_a[2]);
          if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, 2);
          last_acc = cyc;
          nacc++;
        end
        step();
        if (acc) begin
          req_addr_a[2]  = 32'h0000_0010 + nacc;
          req_wdata_a[2] = 32'hC0DE_0000 + nacc;
        end
        prev_acc = acc;
      end
      req_valid_a[2] = 1'b0;
      chk("b2b_accepts", nacc, 6);
      step();
      step();
    end
    do_req(2, 4'b0000, 32'h0000_0012, 32'h0000_0000, 32'hC0DE_0002, 1'b0, 0);

    step();
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
